number_rom_arbiter: RTL
=======================

NUMBER_ROM_ARBITER -- requirements
Module: number_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_W, default 4, width of glyph select.
REQ-002 SHALL have parameter CNT_W, default 8, width of glyph pixel address.
REQ-003 SHALL have parameter MAX_BURST, default 16, max consecutive grant cycles while the other requester waits; legal range 2..255.
REQ-004 SHALL have port clock_25  in  1  pixel clock; the only clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_score / req_time  in  1 each  access request from score_controller / time_controller.
REQ-007 SHALL have ports score_number, time_number  in  NUM_W each  requested glyph.
REQ-008 SHALL have ports score_count, time_count  in  CNT_W each  requested pixel address.
REQ-009 SHALL have port rom_pixel  in  1  numbers ROM data, valid one cycle after address.
REQ-010 SHALL have ports gnt_score / gnt_time  out  1 each  registered grants, one-hot or zero.
REQ-011 SHALL have ports selected_number  out  NUM_W, number_count  out  CNT_W  ROM address to numbers.
REQ-012 SHALL have ports pixel_valid  out  1, pixel_out  out  1, pixel_owner  out  1 (0=score, 1=time)  returned ROM data.

Function
REQ-013 SHALL implement FSM states IDLE, OWN_S, OWN_T; gnt_score=1 only in OWN_S, gnt_time=1 only in OWN_T.
REQ-014 IDLE: no request -> stay; one request -> that owner next cycle; both -> per arbitration policy (REQ-023/024).
REQ-015 OWN_x: stay while req_x=1 and burst counter < MAX_BURST-1 or other request low.
REQ-016 OWN_x, req_x drops: go to other owner next cycle if its req=1 (no IDLE bubble), else IDLE.
REQ-017 Burst counter: clears on entering any OWN state, increments each owned cycle, saturates at MAX_BURST-1; at MAX_BURST-1 with other req=1, forced switch next cycle even if req_x=1.
REQ-018 selected_number/number_count SHALL be combinational mux of the owner's inputs; all zeros when IDLE or when owner's req=0.
REQ-019 ROM issue this cycle = (OWN_S & req_score) | (OWN_T & req_time).
REQ-020 pixel_valid SHALL equal ROM issue delayed one cycle; pixel_owner = owner delayed one cycle; pixel_out = rom_pixel when pixel_valid else 0.
REQ-021 Grant switch SHALL not corrupt return path: a pixel issued in last cycle of OWN_S returns with pixel_owner=0 even though gnt_time=1 that cycle.
REQ-022 Simultaneous req drop and forced switch: req drop rule (REQ-016) governs.

Configuration
REQ-023 With ARB_ROUND_ROBIN_EN defined: in IDLE with both requests, grant the requester not served most recently (last_owner register, reset value time, so score wins first).
REQ-024 Without ARB_ROUND_ROBIN_EN: fixed priority, score wins in IDLE ties; REQ-017 burst limit still applies.

Reset
REQ-025 On reset=1 at clock_25 edge: state IDLE, gnt_score=0, gnt_time=0, burst counter 0, pixel_valid=0, pixel_owner=0, pixel_out=0, last_owner=time.
REQ-026 Reset mid-burst SHALL drop grants next edge and suppress the in-flight pixel (pixel_valid=0 the cycle after reset).
REQ-027 While reset=1, selected_number and number_count SHALL be 0.

Verification
REQ-028 Reset, req_score=1, score_number=3, score_count=8'h15 -> gnt_score=1 next cycle; selected_number=3, number_count=8'h15; pixel_valid=1, pixel_owner=0 one cycle later.
REQ-029 req_score and req_time rise together from IDLE -> gnt_score first (both configs); second tie from IDLE after score-only burst -> gnt_time with ARB_ROUND_ROBIN_EN, gnt_score without.
REQ-030 req_score held high 40 cycles, req_time high from cycle 2 -> gnt_score for exactly 16 cycles, then gnt_time 16 cycles or until req_time drops.
REQ-031 OWN_S, req_score falls while req_time=1 -> gnt_time next cycle, no IDLE cycle; last score pixel returns with pixel_owner=0.
REQ-032 reset pulsed during OWN_T with pixel in flight -> gnt_time=0 and pixel_valid=0 on next cycle; outputs 0.
REQ-033 No requests for 100 cycles -> state IDLE, addresses 0, pixel_valid never 1.

Source files
------------

// File: rtl/number_rom_arbiter.sv
// number_rom_arbiter: shares the single numbers glyph ROM between the score and
// time display controllers. Grants are one-hot (or zero), a burst counter keeps
// one controller from starving the other, and the ROM return path carries the
// owner that issued each address so a grant switch never mislabels a pixel.
// Optional build macro: ARB_ROUND_ROBIN_EN -- IDLE ties go to the requester that
// was not served most recently; without it score always wins IDLE ties.
module number_rom_arbiter #(
    parameter int NUM_W     = 4,
    parameter int CNT_W     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic             req_score,
    input  logic             req_time,
    input  logic [NUM_W-1:0] score_number,
    input  logic [NUM_W-1:0] time_number,
    input  logic [CNT_W-1:0] score_count,
    input  logic [CNT_W-1:0] time_count,
    input  logic             rom_pixel,
    output logic             gnt_score,
    output logic             gnt_time,
    output logic [NUM_W-1:0] selected_number,
    output logic [CNT_W-1:0] number_count,
    output logic             pixel_valid,
    output logic             pixel_out,
    output logic             pixel_owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_S = 2'b01,
        OWN_T = 2'b10
    } state_t;

    // Last owned cycle index before a waiting requester forces a switch.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] burst_r;
    logic       burst_done_s;
    logic       tie_pick_time_s;
    logic       issue_score_s;
    logic       issue_time_s;
    logic       issue_s;

    assign burst_done_s  = (burst_r == BURST_LAST);
    assign issue_score_s = (state_r == OWN_S) && req_score;
    assign issue_time_s  = (state_r == OWN_T) && req_time;
    assign issue_s       = issue_score_s || issue_time_s;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = score served most recently, 1 = time; reset to time so score wins first.
    logic last_owner_r;

    // Track the most recently served requester for fair IDLE tie-breaking.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            last_owner_r <= 1'b1;
        end else if (state_r == OWN_S) begin
            last_owner_r <= 1'b0;
        end else if (state_r == OWN_T) begin
            last_owner_r <= 1'b1;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end

    assign tie_pick_time_s = ~last_owner_r;
`else
    assign tie_pick_time_s = 1'b0;
`endif

    // Next-state decision: request drop beats the burst limit, no IDLE bubble on hand-over.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_score && req_time) begin
                    next_state_s = tie_pick_time_s ? OWN_T : OWN_S;
                end else if (req_score) begin
                    next_state_s = OWN_S;
                end else if (req_time) begin
                    next_state_s = OWN_T;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN_S: begin
                if (!req_score) begin
                    next_state_s = req_time ? OWN_T : IDLE;
                end else if (req_time && burst_done_s) begin
                    next_state_s = OWN_T;
                end else begin
                    next_state_s = OWN_S;
                end
            end
            OWN_T: begin
                if (!req_time) begin
                    next_state_s = req_score ? OWN_S : IDLE;
                end else if (req_score && burst_done_s) begin
                    next_state_s = OWN_S;
                end else begin
                    next_state_s = OWN_T;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Arbiter state, registered grants and the saturating burst counter.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_r   <= IDLE;
            gnt_score <= 1'b0;
            gnt_time  <= 1'b0;
            burst_r   <= 8'd0;
        end else begin
            state_r   <= next_state_s;
            gnt_score <= (next_state_s == OWN_S);
            gnt_time  <= (next_state_s == OWN_T);
            if ((next_state_s == IDLE) || (next_state_s != state_r)) begin
                burst_r <= 8'd0;
            end else if (!burst_done_s) begin
                burst_r <= burst_r + 8'd1;
            end else begin
                burst_r <= burst_r;
            end
        end
    end

    // ROM address mux: only an owner that is still requesting drives the ROM.
    always_comb begin
        selected_number = {NUM_W{1'b0}};
        number_count    = {CNT_W{1'b0}};
        if (reset) begin
            selected_number = {NUM_W{1'b0}};
            number_count    = {CNT_W{1'b0}};
        end else if (issue_score_s) begin
            selected_number = score_number;
            number_count    = score_count;
        end else if (issue_time_s) begin
            selected_number = time_number;
            number_count    = time_count;
        end else begin
            selected_number = {NUM_W{1'b0}};
            number_count    = {CNT_W{1'b0}};
        end
    end

    // Return path: the owner travels with the read so a grant switch cannot relabel it.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            pixel_valid <= 1'b0;
            pixel_owner <= 1'b0;
        end else begin
            pixel_valid <= issue_s;
            pixel_owner <= (state_r == OWN_T);
        end
    end

    assign pixel_out = pixel_valid & rom_pixel;

endmodule
